// File: rtl/lsu_bus_if.sv
// Request/acknowledge data-memory bus between the LSU adapter and memory.
// master drives the request side; slave returns ack and read data.
interface lsu_bus_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/lsu_bus_adapter.sv
// LSU to req/ack bus adapter: one aligned, byte-enabled transfer per access.
// Define LSU_TIMEOUT_EN to bound the bus wait to TIMEOUT_CYCLES.
module lsu_bus_adapter #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        mem_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              access_fault,
  lsu_bus_if.master         bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t      state;
  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        illegal;
  logic        misal;
  logic        legal;
  logic        fault_now;
  logic        tmo_fault;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] rdata_q;
  logic [31:0] ld_val;
  logic [2:0]  mode_q;
  logic [1:0]  lane_q;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             tmo_q;
  assign tmo_fault = tmo_q;
`else
  localparam int tmo_unused = TIMEOUT_CYCLES;
  assign tmo_fault = 1'b0;
`endif

  always_comb begin
    access  = rd_en | wr_en;
    is_byte = (mem_mode == 3'b000) | (mem_mode == 3'b011);
    is_half = (mem_mode == 3'b001) | (mem_mode == 3'b100);
    is_word = (mem_mode == 3'b010);
    illegal = wr_en ? (mem_mode > 3'b010) : (mem_mode > 3'b100);
    misal   = (is_half & addr[0]) |
              (is_word & (addr[1:0] != 2'b00));
    legal   = access & ~illegal & ~misal;
    fault_now = (state == IDLE) & access & ~legal;
    be   = 4'b1111;
    wrep = wdata;
    unique case (1'b1)
      is_byte: begin
        be   = 4'b0001 << addr[1:0];
        wrep = {4{wdata[7:0]}};
      end
      is_half: begin
        be   = addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select uses the address latched at request time.
  always_comb begin
    ld_b = bus.bus_rdata[{lane_q, 3'b000} +: 8];
    ld_h = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    unique case (mode_q)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b011:  ld_val = {24'h0, ld_b};
      3'b100:  ld_val = {16'h0, ld_h};
      default: ld_val = bus.bus_rdata;
    endcase
  end

  assign stall        = ((state == IDLE) & legal) | (state == REQ);
  assign access_fault = fault_now | tmo_fault;
  assign rdata        = fault_now ? 32'h0 : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= 4'b0000;
      bus.bus_wdata <= 32'h0;
      rdata_q       <= 32'h0;
      mode_q        <= 3'b000;
      lane_q        <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      wait_cnt      <= '0;
      tmo_q         <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (legal) begin
            state         <= REQ;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= wr_en;
            bus.bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus.bus_be    <= be;
            bus.bus_wdata <= wrep;
            mode_q        <= mem_mode;
            lane_q        <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            state       <= DONE;
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) rdata_q <= ld_val;
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= DONE;
            bus.bus_req <= 1'b0;
            rdata_q     <= 32'h0;
            tmo_q       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
`ifdef LSU_TIMEOUT_EN
          tmo_q <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule
